// File: rtl/pipe_ctl_pkg.sv
// rtl/pipe_ctl_pkg.sv - default geometry of the valid/PC/ctl pipe and the per-stage kill reach function
package pipe_ctl_pkg;

  localparam int PIPE_DEPTH       = 6;
  localparam int PIPE_PC_W        = 32;
  localparam int PIPE_CTL_W       = 1;
  localparam int PIPE_CTL_STAGE   = 3;
  localparam int PIPE_KILL_LO_STG = 3;
  localparam int PIPE_KILL_HI_STG = 5;
  localparam int PIPE_CNT_W       = 16;

  // Stage numbers are 1-based; a stage is killed if it lies within either active reach.
  function automatic logic stage_kill(input int stg, input int lo_stg, input int hi_stg,
                                      input logic kill_lo, input logic kill_hi);
    return (kill_lo && (stg <= lo_stg)) || (kill_hi && (stg <= hi_stg));
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - enabled data register with asynchronous active-low reset
module pipe_stage_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/valid_pipe_param.sv
// rtl/valid_pipe_param.sv - valid/PC/ctl tracking pipe with two-reach branch kill; perf counters under PIPE_PERF_EN
module valid_pipe_param
  import pipe_ctl_pkg::*;
#(
  parameter int DEPTH       = PIPE_DEPTH,
  parameter int PC_W        = PIPE_PC_W,
  parameter int CTL_W       = PIPE_CTL_W,
  parameter int CTL_STAGE   = PIPE_CTL_STAGE,
  parameter int KILL_LO_STG = PIPE_KILL_LO_STG,
  parameter int KILL_HI_STG = PIPE_KILL_HI_STG,
  parameter int CNT_W       = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             r_,
  input  logic             en,
  input  logic             issue,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [CTL_W-1:0] ctl_in,
  input  logic             kill_lo,
  input  logic             kill_hi,
  output logic [DEPTH-1:0] v_vec,
  output logic             v_out,
  output logic [PC_W-1:0]  pc_out,
  output logic [CTL_W-1:0] ctl_out,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_retired,
  output logic [CNT_W-1:0] perf_killed
);

  logic [DEPTH-1:0] kill_vec;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] v_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      kill_vec[i] = stage_kill(i + 1, KILL_LO_STG, KILL_HI_STG, kill_lo, kill_hi);
    end
  end

  // Kill is applied in place on a stall, and on the way to the next stage on an advance.
  always_comb begin
    v_d = v_q & ~kill_vec;
    if (en) begin
      v_d[0] = issue;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i] = v_q[i-1] & ~kill_vec[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge r_) begin
    if (!r_) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  logic [PC_W-1:0]  pc_stage  [DEPTH+1];
  logic [CTL_W-1:0] ctl_stage [CTL_STAGE:DEPTH];

  assign pc_stage[0]          = pc_in;
  assign ctl_stage[CTL_STAGE] = ctl_in;

  for (genvar g = 1; g <= DEPTH; g++) begin : g_pc
    pipe_stage_reg #(.WIDTH(PC_W)) u_pc (
      .clk   (clk),
      .rst_n (r_),
      .en    (en),
      .d     (pc_stage[g-1]),
      .q     (pc_stage[g])
    );
  end

  for (genvar g = CTL_STAGE + 1; g <= DEPTH; g++) begin : g_ctl
    pipe_stage_reg #(.WIDTH(CTL_W)) u_ctl (
      .clk   (clk),
      .rst_n (r_),
      .en    (en),
      .d     (ctl_stage[g-1]),
      .q     (ctl_stage[g])
    );
  end

  assign v_vec   = v_q;
  assign v_out   = v_q[DEPTH-1];
  assign pc_out  = pc_stage[DEPTH];
  assign ctl_out = ctl_stage[DEPTH];

`ifdef PIPE_PERF_EN
  localparam int SUM_W = CNT_W + $clog2(DEPTH + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [CNT_W-1:0] retired_d;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] killed_d;
  logic [CNT_W-1:0] killed_q;
  logic [SUM_W-1:0] kill_pop;
  logic [SUM_W-1:0] kill_sum;

  always_comb begin
    kill_pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_pop = kill_pop + SUM_W'(v_q[i] & kill_vec[i]);
    end
    kill_sum  = SUM_W'(killed_q) + kill_pop;
    retired_d = retired_q;
    killed_d  = killed_q;
    if (perf_clr) begin
      retired_d = '0;
      killed_d  = '0;
    end else begin
      if (en && v_q[DEPTH-1] && (retired_q != {CNT_W{1'b1}})) begin
        retired_d = retired_q + CNT_W'(1);
      end
      killed_d = (kill_sum > CNT_MAX) ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge r_) begin
    if (!r_) begin
      retired_q <= '0;
      killed_q  <= '0;
    end else begin
      retired_q <= retired_d;
      killed_q  <= killed_d;
    end
  end

  assign perf_retired = retired_q;
  assign perf_killed  = killed_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_retired    = '0;
  assign perf_killed     = '0;
`endif

endmodule

// File: tb/tb_valid_pipe_param.sv
// tb/tb_valid_pipe_param.sv - self-checking bench for valid_pipe_param (perf expectations follow PIPE_PERF_EN)
module tb_valid_pipe_param;

  logic        clk = 1'b0;
  logic        r_ = 1'b0;
  logic        en = 1'b0;
  logic        issue = 1'b0;
  logic [31:0] pc_in = '0;
  logic [0:0]  ctl_in = '0;
  logic        kill_lo = 1'b0;
  logic        kill_hi = 1'b0;
  logic        perf_clr = 1'b0;
  logic [5:0]  v_vec;
  logic        v_out;
  logic [31:0] pc_out;
  logic [0:0]  ctl_out;
  logic [3:0]  perf_retired;
  logic [3:0]  perf_killed;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q [$];
  int n_ret = 0;

  always #5 clk = ~clk;

  valid_pipe_param #(.CNT_W(4)) dut (
    .clk          (clk),
    .r_           (r_),
    .en           (en),
    .issue        (issue),
    .pc_in        (pc_in),
    .ctl_in       (ctl_in),
    .kill_lo      (kill_lo),
    .kill_hi      (kill_hi),
    .v_vec        (v_vec),
    .v_out        (v_out),
    .pc_out       (pc_out),
    .ctl_out      (ctl_out),
    .perf_clr     (perf_clr),
    .perf_retired (perf_retired),
    .perf_killed  (perf_killed)
  );

  typedef struct {
    logic       en;
    logic       issue;
    logic       klo;
    logic       khi;
    logic [5:0] exp_v;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1'b0; issue = 1'b0; pc_in = '0; ctl_in = '0;
    kill_lo = 1'b0; kill_hi = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    r_ = 1'b0;
    tick();
    tick();
    r_ = 1'b1;
  endtask

  // Retires are checked against the scoreboard on the edge that moves them out of stage 6.
  task automatic sb_cycle();
    if (v_out && en) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(v_out), 64'(0));
      end else begin
        check("sb_pc_out", 64'(pc_out), 64'(sb_q.pop_front()));
        n_ret++;
      end
    end
    if (en && issue) sb_q.push_back(pc_in);
    tick();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000001};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000011};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000111};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b001111};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b011111};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b111111};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b110001};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b100011};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000111};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b000000};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000001};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000010};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b000001};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000011};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'b000000};

    // Reset state
    idle_inputs();
    @(negedge clk);
    check("rst_v_vec", 64'(v_vec), 64'(0));
    check("rst_pc_out", 64'(pc_out), 64'(0));
    check("rst_ctl_out", 64'(ctl_out), 64'(0));
    check("rst_perf_retired", 64'(perf_retired), 64'(0));
    check("rst_perf_killed", 64'(perf_killed), 64'(0));
    r_ = 1'b1;

    // Single issue latency, ctl injected as the entry leaves stage 3
    for (int e = 1; e <= 7; e++) begin
      en = 1'b1;
      issue = (e == 1);
      pc_in = (e == 1) ? 32'h100 : 32'h0;
      ctl_in = (e == 4) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("lat_v_out_e%0d", e), 64'(v_out), 64'(e == 6));
      if (e == 5) check("lat_ctl_out_e5", 64'(ctl_out), 64'(0));
      if (e == 6) begin
        check("lat_pc_out", 64'(pc_out), 64'(32'h100));
        check("lat_ctl_out_e6", 64'(ctl_out), 64'(1));
      end
    end

    // Table-driven valid/kill vectors
    do_reset();
    for (int i = 0; i < 16; i++) begin
      en = vecs[i].en;
      issue = vecs[i].issue;
      kill_lo = vecs[i].klo;
      kill_hi = vecs[i].khi;
      tick();
      check($sformatf("vec%0d_v_vec", i), 64'(v_vec), 64'(vecs[i].exp_v));
    end

    // Stall with kill_hi on a full pipe
    do_reset();
    for (int i = 0; i < 6; i++) begin
      en = 1'b1; issue = 1'b1; pc_in = 32'h200 + 32'(i);
      tick();
    end
    idle_inputs();
    check("stall_pre_v_vec", 64'(v_vec), 64'(6'b111111));
    check("stall_pre_pc_out", 64'(pc_out), 64'(32'h200));
    en = 1'b0; kill_hi = 1'b1;
    tick();
    kill_hi = 1'b0;
    check("stall_kill_v_vec", 64'(v_vec), 64'(6'b100000));
    check("stall_kill_pc_out", 64'(pc_out), 64'(32'h200));
`ifdef PIPE_PERF_EN
    check("stall_perf_killed", 64'(perf_killed), 64'(5));
`else
    check("stall_perf_killed", 64'(perf_killed), 64'(0));
`endif
    check("stall_perf_retired", 64'(perf_retired), 64'(0));
    en = 1'b1;
    tick();
    check("post_stall_v_out", 64'(v_out), 64'(0));
    check("post_stall_pc_out", 64'(pc_out), 64'(32'h201));

    // Reset asserted mid-flight
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      en = 1'b1; ctl_in = 1'b1;
      issue = (e == 1 || e == 3 || e == 4 || e == 6);
      pc_in = 32'h300 + 32'(e);
      tick();
    end
    check("mid_pre_v_vec", 64'(v_vec), 64'(6'b101101));
    check("mid_pre_pc_out", 64'(pc_out), 64'(32'h301));
    check("mid_pre_ctl_out", 64'(ctl_out), 64'(1));
    #2 r_ = 1'b0;
    #1;
    check("mid_rst_v_vec", 64'(v_vec), 64'(0));
    check("mid_rst_pc_out", 64'(pc_out), 64'(0));
    check("mid_rst_ctl_out", 64'(ctl_out), 64'(0));
    @(negedge clk);
    idle_inputs();
    r_ = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      en = 1'b1; issue = (e == 1); pc_in = 32'h400;
      tick();
      check($sformatf("mid_post_v_out_e%0d", e), 64'(v_out), 64'(e == 6));
    end
    check("mid_post_pc_out", 64'(pc_out), 64'(32'h400));

    // Counter saturation and clear priority
    do_reset();
    for (int e = 0; e < 26; e++) begin
      en = 1'b1; issue = 1'b1;
      tick();
    end
`ifdef PIPE_PERF_EN
    check("sat_perf_retired", 64'(perf_retired), 64'(15));
`else
    check("sat_perf_retired", 64'(perf_retired), 64'(0));
`endif
    check("sat_v_out", 64'(v_out), 64'(1));
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("clr_perf_retired", 64'(perf_retired), 64'(0));
    check("clr_perf_killed", 64'(perf_killed), 64'(0));

    // Random stream against the scoreboard
    do_reset();
    n_ret = 0;
    for (int c = 0; c < 60; c++) begin
      en = ($urandom_range(0, 3) != 0);
      issue = $urandom_range(0, 1);
      pc_in = $urandom;
      sb_cycle();
    end
    issue = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 7; c++) sb_cycle();
    check("sb_drained", 64'(sb_q.size()), 64'(0));
`ifdef PIPE_PERF_EN
    check("sb_perf_retired", 64'(perf_retired), 64'((n_ret > 15) ? 15 : n_ret));
`else
    check("sb_perf_retired", 64'(perf_retired), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
